seg_display_monitor: RTL and testbench

- Receive-side checker for the two-digit 7-segment bus driven by the stopwatch display encoder (units and tens, 9-bit patterns, bit0 = segment a … bit6 = segment g).
- Synchronises and glitch-filters the two segment buses, then decodes stable patterns back to BCD digits.
- Flags illegal patterns and out-of-sequence count updates; measures clock cycles between accepted updates.
- Used on-board for display self-test and in simulation as the scoreboard front end for the stopwatch.

---
 rtl/seg_display_monitor.sv | 186 ++++++++++++++++++
 tb/tb_seg_display_monitor.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/seg_display_monitor.sv
// Receive-side monitor for the two-digit 7-segment stopwatch display bus.
// Synchronises and glitch-filters the segment patterns, decodes them to BCD,
// flags illegal patterns and out-of-sequence updates, and measures the
// interval between accepted values.
module seg_display_monitor #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned INT_W         = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [8:0]       seg_units,
    input  logic [8:0]       seg_tens,
    output logic [3:0]       digit_units,
    output logic [3:0]       digit_tens,
    output logic             valid,
    output logic             invalid_err,
    output logic             seq_err,
    output logic             locked,
    output logic [INT_W-1:0] interval,
    output logic [7:0]       err_count
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);

    typedef enum logic {
        IDLE,
        TRACK
    } state_t;

    state_t            state;
    state_t            state_next;

    // Pairs are held as {tens, units}.
    logic [17:0]       sync_a;
    logic [17:0]       sync_b;
    logic [17:0]       prev_pair;
    logic [17:0]       acc_pair;
    logic [CNT_W-1:0]  stab_cnt;
    logic [CNT_W-1:0]  stab_next;
    logic [INT_W-1:0]  int_cnt;

    logic              accept;
    logic              legal;
    logic              units_ok;
    logic              tens_ok;
    logic [3:0]        units_dig;
    logic [3:0]        tens_dig;
    logic [6:0]        new_val;
    logic [6:0]        cur_val;
    logic [6:0]        exp_val;
    logic              valid_next;
    logic              invalid_next;
    logic              seq_next;

    // Returns {legal, digit} for one 9-bit segment pattern.
    function automatic logic [4:0] decode(input logic [8:0] pat);
        case (pat)
            9'h03F:  return {1'b1, 4'd0};
            9'h006:  return {1'b1, 4'd1};
            9'h05B:  return {1'b1, 4'd2};
            9'h04F:  return {1'b1, 4'd3};
            9'h066:  return {1'b1, 4'd4};
            9'h06D:  return {1'b1, 4'd5};
            9'h07D:  return {1'b1, 4'd6};
            9'h007:  return {1'b1, 4'd7};
            9'h07F:  return {1'b1, 4'd8};
            9'h06F:  return {1'b1, 4'd9};
            default: return 5'd0;
        endcase
    endfunction

    // Two-flop synchroniser on both segment buses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= {seg_tens, seg_units};
            sync_b <= sync_a;
        end
    end

    // Next stability count and acceptance decision. Acceptance uses the
    // count value being written this cycle so outputs land one edge earlier
    // than a registered-count compare would give.
    always_comb begin
        stab_next = stab_cnt;
        if (sync_b != prev_pair) begin
            stab_next = CNT_W'(1);
        end else if (stab_cnt != CNT_W'(STABLE_CYCLES)) begin
            stab_next = stab_cnt + CNT_W'(1);
        end
        accept = (stab_next == CNT_W'(STABLE_CYCLES)) && (sync_b != acc_pair);
    end

    // Decode, sequence check and FSM next-state.
    always_comb begin
        {units_ok, units_dig} = decode(sync_b[8:0]);
        {tens_ok, tens_dig}   = decode(sync_b[17:9]);
        legal        = units_ok && tens_ok;
        new_val      = 7'(tens_dig) * 7'd10 + 7'(units_dig);
        cur_val      = 7'(digit_tens) * 7'd10 + 7'(digit_units);
        exp_val      = (cur_val == 7'd99) ? 7'd0 : cur_val + 7'd1;
        state_next   = state;
        valid_next   = 1'b0;
        invalid_next = 1'b0;
        seq_next     = 1'b0;
        if (accept) begin
            if (!legal) begin
                invalid_next = 1'b1;
            end else begin
                valid_next = 1'b1;
                case (state)
                    IDLE:    state_next = TRACK;
                    TRACK:   seq_next   = (new_val != exp_val);
                    default: state_next = IDLE;
                endcase
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Stability filter and accepted-pattern register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_pair <= '0;
            stab_cnt  <= '0;
            acc_pair  <= '0;
        end else begin
            prev_pair <= sync_b;
            stab_cnt  <= stab_next;
            if (accept) begin
                acc_pair <= sync_b;
            end
        end
    end

    // Interval counter: restarts at 1 after each legal acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            int_cnt  <= '0;
            interval <= '0;
        end else begin
            if (valid_next) begin
                int_cnt  <= INT_W'(1);
                interval <= (state == IDLE) ? '0 : int_cnt;
            end else if (int_cnt != '1) begin
                int_cnt <= int_cnt + INT_W'(1);
            end
        end
    end

    // Registered outputs: digits, pulses, lock flag and error counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            digit_units <= '0;
            digit_tens  <= '0;
            valid       <= 1'b0;
            invalid_err <= 1'b0;
            seq_err     <= 1'b0;
            locked      <= 1'b0;
            err_count   <= '0;
        end else begin
            valid       <= valid_next;
            invalid_err <= invalid_next;
            seq_err     <= seq_next;
            if (valid_next) begin
                digit_units <= units_dig;
                digit_tens  <= tens_dig;
                locked      <= 1'b1;
            end
            if ((invalid_next || seq_next) && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_seg_display_monitor.sv
// Directed self-checking bench for seg_display_monitor.
module tb_seg_display_monitor;

    localparam int unsigned STABLE_CYCLES = 4;
    localparam int unsigned INT_W         = 24;
    localparam int          HOLD          = 50;

    logic             clk;
    logic             rst;
    logic [8:0]       seg_units;
    logic [8:0]       seg_tens;
    logic [3:0]       digit_units;
    logic [3:0]       digit_tens;
    logic             valid;
    logic             invalid_err;
    logic             seq_err;
    logic             locked;
    logic [INT_W-1:0] interval;
    logic [7:0]       err_count;

    int checks = 0;
    int fails  = 0;

    logic [8:0] seg_tab [10] = '{9'h03F, 9'h006, 9'h05B, 9'h04F, 9'h066,
                                 9'h06D, 9'h07D, 9'h007, 9'h07F, 9'h06F};

    seg_display_monitor #(
        .STABLE_CYCLES(STABLE_CYCLES),
        .INT_W(INT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .seg_units(seg_units),
        .seg_tens(seg_tens),
        .digit_units(digit_units),
        .digit_tens(digit_tens),
        .valid(valid),
        .invalid_err(invalid_err),
        .seq_err(seq_err),
        .locked(locked),
        .interval(interval),
        .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a pattern pair, expect the outcome exactly STABLE_CYCLES+2 edges later.
    task automatic step(input logic [8:0] pt, input logic [8:0] pu,
                        input logic ev_v, input logic ev_i, input logic ev_s,
                        input logic [3:0] dt, input logic [3:0] du, input int hold);
        logic early;
        seg_tens  = pt;
        seg_units = pu;
        early     = 1'b0;
        repeat (5) begin
            tick();
            early |= valid | invalid_err | seq_err;
        end
        chk("early_pulse", 32'(early), 32'd0);
        tick();
        chk("valid", 32'(valid), 32'(ev_v));
        chk("invalid_err", 32'(invalid_err), 32'(ev_i));
        chk("seq_err", 32'(seq_err), 32'(ev_s));
        chk("digits", 32'({digit_tens, digit_units}), 32'({dt, du}));
        tick();
        chk("pulse_width", 32'({valid, invalid_err, seq_err}), 32'd0);
        repeat (hold - 7) tick();
    endtask

    initial begin
        logic seen;
        int   v;

        rst       = 1'b0;
        seg_units = '0;
        seg_tens  = '0;
        repeat (3) tick();
        chk("reset_outputs", 32'({digit_tens, digit_units, valid, invalid_err, seq_err, locked}), 32'd0);
        chk("reset_interval", 32'(interval), 32'd0);
        chk("reset_err_count", 32'(err_count), 32'd0);

        // First legal value: IDLE path.
        rst = 1'b1;
        step(seg_tab[0], seg_tab[0], 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, HOLD);
        chk("first_locked", 32'(locked), 32'd1);
        chk("first_interval", 32'(interval), 32'd0);

        // Full sweep 01..99 and wrap to 00.
        for (int n = 1; n <= 100; n++) begin
            v = n % 100;
            step(seg_tab[v / 10], seg_tab[v % 10], 1'b1, 1'b0, 1'b0,
                 4'(v / 10), 4'(v % 10), HOLD);
            chk("sweep_interval", 32'(interval), 32'(HOLD));
        end
        chk("sweep_err_count", 32'(err_count), 32'd0);

        for (int n = 1; n <= 5; n++) begin
            step(seg_tab[0], seg_tab[n], 1'b1, 1'b0, 1'b0, 4'd0, 4'(n), 20);
        end
        chk("interval_20", 32'(interval), 32'd20);

        // Three-sample glitch to 8, back to 5.
        seg_units = seg_tab[8];
        repeat (3) tick();
        seg_units = seg_tab[5];
        seen = 1'b0;
        repeat (15) begin
            tick();
            seen |= valid | invalid_err | seq_err;
        end
        chk("glitch_pulse", 32'(seen), 32'd0);
        chk("glitch_digits", 32'({digit_tens, digit_units}), 32'h05);
        chk("glitch_err_count", 32'(err_count), 32'd0);

        // Held illegal units pattern pulses once.
        step(seg_tab[0], 9'h02A, 1'b0, 1'b1, 1'b0, 4'd0, 4'd5, 20);
        chk("illegal_err_count", 32'(err_count), 32'd1);
        seen = 1'b0;
        repeat (20) begin
            tick();
            seen |= invalid_err;
        end
        chk("illegal_once", 32'(seen), 32'd0);
        step(seg_tab[0], seg_tab[6], 1'b1, 1'b0, 1'b0, 4'd0, 4'd6, 20);

        for (int n = 7; n <= 12; n++) begin
            step(seg_tab[n / 10], seg_tab[n % 10], 1'b1, 1'b0, 1'b0,
                 4'(n / 10), 4'(n % 10), 20);
        end

        // 12 -> 15 is out of sequence.
        step(seg_tab[1], seg_tab[5], 1'b1, 1'b0, 1'b1, 4'd1, 4'd5, 20);
        chk("seq_err_count", 32'(err_count), 32'd2);

        // Bit 8 set on an otherwise valid tens pattern is illegal.
        step(9'h13F, seg_tab[5], 1'b0, 1'b1, 1'b0, 4'd1, 4'd5, 20);
        chk("hibit_err_count", 32'(err_count), 32'd3);

        step(seg_tab[4], seg_tab[7], 1'b1, 1'b0, 1'b1, 4'd4, 4'd7, 20);
        chk("jump_err_count", 32'(err_count), 32'd4);

        // Asynchronous reset mid-operation.
        rst = 1'b0;
        #2;
        chk("midrst_outputs", 32'({digit_tens, digit_units, valid, invalid_err, seq_err, locked}), 32'd0);
        chk("midrst_err_count", 32'(err_count), 32'd0);
        chk("midrst_interval", 32'(interval), 32'd0);
        rst = 1'b1;
        step(seg_tab[4], seg_tab[8], 1'b1, 1'b0, 1'b0, 4'd4, 4'd8, 20);
        chk("relock_locked", 32'(locked), 32'd1);
        chk("relock_interval", 32'(interval), 32'd0);
        chk("relock_err_count", 32'(err_count), 32'd0);

        // Error counter saturation with alternating illegal patterns.
        for (int n = 0; n < 260; n++) begin
            seg_units = (n % 2 == 0) ? 9'h02A : 9'h02B;
            repeat (6) tick();
        end
        chk("sat_err_count", 32'(err_count), 32'd255);
        chk("sat_digits", 32'({digit_tens, digit_units}), 32'h48);
        chk("sat_locked", 32'(locked), 32'd1);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
